// File: rtl/alu_operand_sequencer_if.sv
// Operand-in / result-out bus for alu_operand_sequencer.
//   in_valid/in_ready/in_data    : serial operand stream from the internal data bus
//   res_valid/res_ready/res_data : result handshake toward register-file write-back
//   flag_z/flag_n                : zero / negative status of res_data
//   flag_p                       : parity of res_data (only with ALU_PARITY_FLAG_EN)
// Modports: master = bus side (operand source / result sink), slave = sequencer.
interface alu_operand_sequencer_if #(
    parameter int unsigned N = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         flag_z;
    logic         flag_n;
`ifdef ALU_PARITY_FLAG_EN
    logic         flag_p;

    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, flag_z, flag_n, flag_p
    );
    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, flag_z, flag_n, flag_p
    );
`else
    modport master (
        output in_valid, in_data, res_ready,
        input  in_ready, res_valid, res_data, flag_z, flag_n
    );
    modport slave (
        input  in_valid, in_data, res_ready,
        output in_ready, res_valid, res_data, flag_z, flag_n
    );
`endif
endinterface

// File: rtl/alu_operand_sequencer.sv
// Operand sequencer for the combinational ALU op units.
// Collects operand A then B from the bus, holds them on op_a/op_b, samples the
// op unit result op_y one cycle later, and offers result + flags on the bus.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_operand_sequencer_if.slave (operand in, result out)
//   op_a, op_b : registered operands to the op unit
//   op_y       : combinational result from the op unit
//   busy       : high whenever not IDLE
//   op_count   : completed results, wraps modulo 256
// Optional feature: define ALU_PARITY_FLAG_EN to add flag_p (XOR-reduction of result).
module alu_operand_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_operand_sequencer_if.slave  bus,
    output logic [N-1:0]            op_a,
    output logic [N-1:0]            op_b,
    input  logic [N-1:0]            op_y,
    output logic                    busy,
    output logic [7:0]              op_count
);
    localparam int unsigned CNT_W = 8;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GOT_A = 2'd1;
    localparam logic [1:0] EXEC  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       ready_c;
    logic       busy_c;
    logic       load_a;
    logic       load_b;
    logic       exec_en;
    logic       res_take;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-state strobes; in_ready depends on state only
    always_comb begin
        state_d  = state_q;
        ready_c  = 1'b0;
        busy_c   = 1'b1;
        load_a   = 1'b0;
        load_b   = 1'b0;
        exec_en  = 1'b0;
        res_take = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                busy_c  = 1'b0;
                if (bus.in_valid) begin
                    load_a  = 1'b1;
                    state_d = GOT_A;
                end
            end
            GOT_A: begin
                ready_c = 1'b1;
                if (bus.in_valid) begin
                    load_b  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                exec_en = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_take = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready = ready_c;
    assign busy         = busy_c;

    // Operand capture, result sampling and completion counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a          <= '0;
            op_b          <= '0;
            bus.res_data  <= '0;
            bus.flag_z    <= 1'b0;
            bus.flag_n    <= 1'b0;
            bus.res_valid <= 1'b0;
            op_count      <= '0;
        end else begin
            if (load_a) begin
                op_a <= bus.in_data;
            end
            if (load_b) begin
                op_b <= bus.in_data;
            end
            if (exec_en) begin
                bus.res_data  <= op_y;
                bus.flag_z    <= (op_y == '0);
                bus.flag_n    <= op_y[N-1];
                bus.res_valid <= 1'b1;
                op_count      <= op_count + CNT_W'(1);
            end else if (res_take) begin
                bus.res_valid <= 1'b0;
            end
        end
    end

`ifdef ALU_PARITY_FLAG_EN
    // Parity of the sampled result, held like the other flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.flag_p <= 1'b0;
        end else if (exec_en) begin
            bus.flag_p <= ^op_y;
        end
    end
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized self-checking bench for alu_operand_sequencer with an
// XOR/AND/OR/ADD op unit attached; expected results come from the operands sent.
`timescale 1ns/1ps
module tb_alu_operand_sequencer;
    localparam int unsigned N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] op_a;
    logic [N-1:0] op_b;
    logic [N-1:0] op_y;
    logic         busy;
    logic [7:0]   op_count;
    logic [1:0]   op_sel = 2'd0;

    int unsigned  n_vec   = 0;
    int unsigned  n_err   = 0;
    int unsigned  exp_cnt = 0;

    alu_operand_sequencer_if #(.N(N)) bus ();

    alu_operand_sequencer #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .op_a     (op_a),
        .op_b     (op_b),
        .op_y     (op_y),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;

    // Attached combinational op unit
    always_comb begin
        case (op_sel)
            2'd0:    op_y = op_a ^ op_b;
            2'd1:    op_y = op_a & op_b;
            2'd2:    op_y = op_a | op_b;
            default: op_y = N'(op_a + op_b);
        endcase
    end

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation exceeded time limit (%0d vectors, %0d miscompares)", n_vec, n_err);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_result(input logic [1:0] sel,
                                                input logic [N-1:0] a,
                                                input logic [N-1:0] b);
        case (sel)
            2'd0:    return a ^ b;
            2'd1:    return a & b;
            2'd2:    return a | b;
            default: return N'(int'(a) + int'(b));
        endcase
    endfunction

    // Present one operand until accepted; returns at the negedge after the accepting edge
    task automatic send(input logic [N-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_data  = N'($urandom);
    endtask

    // Send B (A already held) and run the result handshake with 'hold' stall cycles
    task automatic finish_op(input logic [N-1:0] a, input logic [N-1:0] b, input int hold);
        logic [N-1:0] r;
        send(b);
        check("exec_in_ready", 32'(bus.in_ready), 32'd0);
        check("exec_res_valid", 32'(bus.res_valid), 32'd0);
        check("exec_op_a", 32'(op_a), 32'(a));
        check("exec_op_b", 32'(op_b), 32'(b));
        bus.res_ready = (hold == 0);
        @(negedge clk);
        r       = ref_result(op_sel, a, b);
        exp_cnt = (exp_cnt + 1) % 256;
        check("res_valid", 32'(bus.res_valid), 32'd1);
        check("res_data", 32'(bus.res_data), 32'(r));
        check("flag_z", 32'(bus.flag_z), 32'(r == 0));
        check("flag_n", 32'(bus.flag_n), 32'(r[N-1]));
`ifdef ALU_PARITY_FLAG_EN
        check("flag_p", 32'(bus.flag_p), 32'(^r));
`endif
        check("op_count", 32'(op_count), exp_cnt);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.res_valid), 32'd1);
            check("hold_data", 32'(bus.res_data), 32'(r));
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("post_valid", 32'(bus.res_valid), 32'd0);
        check("post_busy", 32'(busy), 32'd0);
        check("post_data_kept", 32'(bus.res_data), 32'(r));
        bus.res_ready = 1'b0;
    endtask

    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input int gap, input int hold);
        send(a);
        check("got_a_op_a", 32'(op_a), 32'(a));
        check("got_a_busy", 32'(busy), 32'd1);
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            check("gap_op_a", 32'(op_a), 32'(a));
            check("gap_in_ready", 32'(bus.in_ready), 32'd1);
        end
        finish_op(a, b, hold);
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.res_ready = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_res_data", 32'(bus.res_data), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic XOR, zero result, gap between operands
        op_sel = 2'd0;
        do_op(8'hA5, 8'h5A, 0, 0);
        check("xor_count_1", 32'(op_count), 32'd1);
        check("xor_res", 32'(bus.res_data), 32'hFF);
        do_op(8'h3C, 8'h3C, 0, 0);
        check("zero_flag_z", 32'(bus.flag_z), 32'd1);
        do_op(8'h0F, 8'h01, 3, 0);
        check("gap_res", 32'(bus.res_data), 32'h0E);

        // Backpressure with a pending operand that must wait for the handshake
        send(8'h12);
        send(8'h34);
        bus.res_ready = 1'b0;
        @(negedge clk);
        exp_cnt = (exp_cnt + 1) % 256;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h11;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_res_valid", 32'(bus.res_valid), 32'd1);
            check("bp_res_data", 32'(bus.res_data), 32'h26);
            check("bp_op_a", 32'(op_a), 32'h12);
            @(negedge clk);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check("bp_released_valid", 32'(bus.res_valid), 32'd0);
        check("bp_released_ready", 32'(bus.in_ready), 32'd1);
        check("bp_count", 32'(op_count), exp_cnt);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("bp_new_a", 32'(op_a), 32'h11);
        finish_op(8'h11, 8'h22, 0);

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            op_sel = 2'($urandom_range(0, 3));
            do_op(N'($urandom), N'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end

        // Reset while holding A
        op_sel = 2'd0;
        send(8'h77);
        check("pre_rst_op_a", 32'(op_a), 32'h77);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_op_a", 32'(op_a), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_count", 32'(op_count), 32'd0);
        check("mid_rst_res_data", 32'(bus.res_data), 32'd0);
        check("mid_rst_flag_n", 32'(bus.flag_n), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("after_rst_valid", 32'(bus.res_valid), 32'd0);
            check("after_rst_busy", 32'(busy), 32'd0);
        end

        // Counter wrap
        for (int k = 1; k <= 256; k++) begin
            op_sel = 2'($urandom_range(0, 3));
            do_op(N'($urandom), N'($urandom), 0, 0);
            if (k == 255) check("cnt_255", 32'(op_count), 32'd255);
            if (k == 256) check("cnt_wrap", 32'(op_count), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
